spine_xbar_router: RTL and testbench
====================================

# spine_xbar_router

Parametrised spine router for the group fabric. It provides N leaf ports plus one port per remote group, each with valid/ready backpressure. Every input has its own FIFO, the destination is decoded from the flit header, and each output is granted by a round-robin arbiter. It replaces the fixed 11-port spine router: the port count and FIFO depth are generic, backpressure is explicit, and unroutable flits are dropped and counted.

## Interface
- `GROUP_ID`, default 8: this router's group number.
- `NUM_GROUPS`, default 8: total groups in the system. Group ports = `NUM_GROUPS-1`.
- `NUM_LEAF`, default 4: leaf ports.
- `DWIDTH`, default 16: flit width. Must be ≥ `GID_W+LID_W+1`.
- `FIFO_DEPTH`, default 8: per-input FIFO depth, power of two, ≥ 2.
- `GID_W`, default 4: width of the group-ID field in the header.
- `LID_W`, default 2: width of the leaf-ID field in the header.
- Derived: `NP = NUM_LEAF + NUM_GROUPS - 1`.
- Ports:
  - `clk`  in  1  sole clock, rising edge.
  - `reset`  in  1  synchronous, active-high.
  - `in_data`  in  `NP*DWIDTH`  ingress flits; port p occupies `[p*DWIDTH +: DWIDTH]`.
  - `in_valid`  in  `NP`  ingress valid.
  - `in_ready`  out  `NP`  ingress ready, `= ~fifo_full[p] & ~reset`.
  - `out_data`  out  `NP*DWIDTH`  egress flits, registered.
  - `out_valid`  out  `NP`  egress valid, registered.
  - `out_ready`  in  `NP`  egress ready from the downstream port.
  - `drop_count`  out  16  count of unroutable flits, saturating.
- Port order: 0..`NUM_LEAF-1` are leaves; `NUM_LEAF`.. are groups in ascending group number, with `GROUP_ID` skipped.

## Operation
- **Header fields.**
  - `dgid = flit[DWIDTH-1 -: GID_W]`
  - `dlid = flit[DWIDTH-1-GID_W -: LID_W]`
- **Route decode.** The header of each FIFO head is decoded combinationally:
  - If `dgid==GROUP_ID` and `dlid<NUM_LEAF`: output = `dlid`.
  - If `dgid!=GROUP_ID` and `dgid<NUM_GROUPS`: output = `NUM_LEAF + (dgid<GROUP_ID ? dgid : dgid-1)`.
  - Otherwise the flit is unroutable. It is popped without being forwarded, and `drop_count` increments, saturating at 0xFFFF.
- **Ingress.** A flit is written into its input FIFO on any cycle where `in_valid & in_ready`. U-turns are legal: a flit may be routed to its own input port index.
- **Arbitration.**
  - Each output has a round-robin pointer `rr[o]`, reset to 0.
  - Requesters are the inputs whose non-empty head routes to `o`.
  - The grant goes to the first requester at or after `rr[o]`, scanning upward with wrap-around.
  - On a grant, `rr[o]` is set to grantee+1 mod NP. With no grant, `rr[o]` is unchanged.
- **Output load.**
  - Output `o` may load when `~out_valid[o] | out_ready[o]`.
  - On a load, `out_data[o]` is set to the head flit, `out_valid[o]` is set to 1, and the granted FIFO pops.
  - If `out_ready` is high with no grant, `out_valid[o]` clears.
  - While `out_valid & ~out_ready`, `out_data` and `out_valid` hold stable.
- **Flit ordering.** An input head can be granted by at most one output, so there is no duplication. Flits from one input leave in arrival order.
- **Drops.** A dropped head pops in the cycle it reaches the head and does not take part in arbitration.
- **Reset.**
  - Applies regardless of in-flight traffic.
  - Clears all FIFOs, `out_valid`, `out_data`, `rr`, and `drop_count`.
  - `in_ready` is 0 while reset is high, and 1 on the first cycle after reset is released.

## Timing
- **Latency.** Minimum latency is 2 cycles: a flit accepted at edge N is presented at the FIFO head in cycle N+1, granted at edge N+1, and `out_valid` is high in cycle N+2.
- **Throughput.** One flit per cycle per output, sustained under `out_ready=1`. No bubble occurs between consecutive grants.
- **Full FIFO.** When a FIFO is full, `in_ready` is 0. A push and a pop in the same cycle on a full FIFO is not possible, because ready is already low. On a non-full FIFO, a simultaneous push and pop leaves the count unchanged.
- **Empty FIFO.** No request is raised, and the pointer wraps naturally.
- **Counter saturation.** `drop_count` at 0xFFFF stays at 0xFFFF.

## Structure
- Package `spine_pkg`:
  - `GID_W`/`LID_W` defaults.
  - A `route_port` function implementing the dgid/dlid-to-output mapping and valid flag.
  - The `drop_count` width constant.
- Sub-module `spine_xbar_fifo`:
  - Synchronous FIFO, parameters `DWIDTH`/`DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout` (head, show-ahead), `empty`, `full`.
  - Instantiated NP times.
- Top level contains per-input route decode, per-output arbiters and output registers, and the drop counter.

## Test plan
- **Single flit, local leaf.** After reset, drive one flit `0x8123` on port 5 (`dgid=8`, `dlid=0`) → `out_valid[0]` high 2 cycles after acceptance with `out_data[0]=0x8123`; all other outputs stay idle.
- **Remote group mapping.** Drive `dgid=3` and `dgid=9`→drop, with defaults → the `dgid=3` flit appears on output 7; the `dgid=9` flit is dropped and `drop_count=1`.
- **Round-robin contention.** Ports 0, 1, and 2 each send 3 flits to leaf 3, with `out_ready=1` → output 3 grant order is 0,1,2,0,1,2,0,1,2 with no idle cycles between them.
- **Backpressure.** Hold `out_ready[1]=0` while port 0 streams to leaf 1 → 1 flit is held on the output and 8 are buffered, then `in_ready[0]=0`. Release `out_ready` → all 9 flits emerge in order; none are lost.
- **Reset mid-traffic.** Assert reset with FIFOs half full and `out_valid` high → the next cycle shows all `out_valid=0`, `drop_count=0`, and `in_ready=0`. After release, `in_ready` is all 1s and no stale flits appear.

Source files
------------

// File: rtl/spine_xbar_router_pkg.sv
// spine_pkg: shared definitions for the spine crossbar router.
//   GID_W_DEF / LID_W_DEF : default header field widths
//   DROP_W                : width of the saturating drop counter
//   route_t / route_port  : header-to-output-port mapping with routable flag
package spine_pkg;

    localparam int GID_W_DEF = 4;
    localparam int LID_W_DEF = 2;
    localparam int DROP_W    = 16;

    typedef struct packed {
        logic        ok;
        logic [15:0] port;
    } route_t;

    // Local group: leaf ports 0..num_leaf-1 addressed by dlid.
    // Remote group: group ports follow the leaves in ascending group order,
    // with our own group number skipped. A computed index past the last
    // port (possible when group_id >= num_groups) is treated as unroutable
    // so it can never select a non-existent output.
    function automatic route_t route_port(input int dgid, input int dlid,
                                          input int group_id, input int num_groups,
                                          input int num_leaf, input int np);
        route_t r;
        int     p;
        r.ok   = 1'b0;
        r.port = '0;
        p      = 0;
        if (dgid == group_id) begin
            if (dlid < num_leaf) begin
                r.ok   = 1'b1;
                r.port = 16'(dlid);
            end
        end else if (dgid < num_groups) begin
            p = num_leaf + ((dgid < group_id) ? dgid : dgid - 1);
            if (p < np) begin
                r.ok   = 1'b1;
                r.port = 16'(p);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spine_xbar_router_if.sv
// spine_xbar_router_if: ingress/egress valid-ready buses of the spine router.
//   in_data/in_valid/in_ready    : NP ingress ports, port p at [p*DWIDTH +: DWIDTH]
//   out_data/out_valid/out_ready : NP egress ports, same packing
//   slave  : router side
//   master : traffic source / sink side
interface spine_xbar_router_if #(
    parameter int NP     = 11,
    parameter int DWIDTH = 16
) ();
    logic [NP*DWIDTH-1:0] in_data;
    logic [NP-1:0]        in_valid;
    logic [NP-1:0]        in_ready;
    logic [NP*DWIDTH-1:0] out_data;
    logic [NP-1:0]        out_valid;
    logic [NP-1:0]        out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/spine_xbar_router_fifo.sv
// spine_xbar_fifo: synchronous show-ahead FIFO, one per router input.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write strobe and data (ignored when full)
//   pop        : consume head (ignored when empty)
//   dout       : current head, valid whenever ~empty
//   empty,full : occupancy flags
module spine_xbar_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic              wr, rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

endmodule

// File: rtl/spine_xbar_router.sv
// spine_xbar_router: NP-port spine router (NUM_LEAF leaves + NUM_GROUPS-1
// group ports). Per-input FIFO, header route decode at each FIFO head,
// per-output round-robin arbiter feeding a registered output stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ingress/egress valid-ready buses (slave modport)
//   drop_count : saturating count of unroutable flits
module spine_xbar_router
    import spine_pkg::*;
#(
    parameter int GROUP_ID   = 8,
    parameter int NUM_GROUPS = 8,
    parameter int NUM_LEAF   = 4,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GID_W      = GID_W_DEF,
    parameter int LID_W      = LID_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    spine_xbar_router_if.slave bus,
    output logic [DROP_W-1:0]  drop_count
);
    localparam int NP = NUM_LEAF + NUM_GROUPS - 1;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    logic [NP-1:0][DWIDTH-1:0] head;
    logic [NP-1:0]             empty, full, push, pop, drop;
    logic [NP-1:0]             route_ok;
    logic [NP-1:0][PW-1:0]     route_dst;
    logic [NP-1:0][NP-1:0]     req;        // [output][input]
    logic [NP-1:0]             load;
    logic [NP-1:0][PW-1:0]     gsel;
    logic [NP-1:0][PW-1:0]     rr;
    logic [NP-1:0][DWIDTH-1:0] out_q;
    logic [NP-1:0]             out_v;
    logic [DROP_W:0]           drop_sum;

    assign bus.in_ready  = ~full & {NP{~reset}};
    assign push          = bus.in_valid & bus.in_ready;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_v;

    for (genvar p = 0; p < NP; p++) begin : g_in
        route_t rt;

        spine_xbar_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (bus.in_data[p*DWIDTH +: DWIDTH]),
            .dout  (head[p]),
            .empty (empty[p]),
            .full  (full[p])
        );

        assign rt = route_port(32'(head[p][DWIDTH-1 -: GID_W]),
                               32'(head[p][DWIDTH-1-GID_W -: LID_W]),
                               GROUP_ID, NUM_GROUPS, NUM_LEAF, NP);
        assign route_ok[p]  = ~empty[p] & rt.ok;
        assign route_dst[p] = PW'(rt.port);
        // Unroutable heads leave immediately and never request an output.
        assign drop[p]      = ~empty[p] & ~rt.ok;
    end

    always_comb begin
        req = '0;
        for (int o = 0; o < NP; o++)
            for (int p = 0; p < NP; p++)
                req[o][p] = route_ok[p] && (route_dst[p] == PW'(o));
    end

    // First requester at or after rr[o], wrapping. Only a loadable output
    // grants, so a stalled output leaves its requesters in their FIFOs.
    always_comb begin
        int   idx;
        logic found;
        load  = '0;
        gsel  = '0;
        idx   = 0;
        found = 1'b0;
        for (int o = 0; o < NP; o++) begin
            found = 1'b0;
            for (int i = 0; i < NP; i++) begin
                idx = int'(rr[o]) + i;
                if (idx >= NP) idx = idx - NP;
                if (!found && req[o][idx]) begin
                    found   = 1'b1;
                    gsel[o] = PW'(idx);
                end
            end
            load[o] = found & (~out_v[o] | bus.out_ready[o]);
        end
    end

    // Each input routes to one output, so at most one grant can pop it.
    always_comb begin
        pop = drop;
        for (int o = 0; o < NP; o++)
            for (int p = 0; p < NP; p++)
                if (load[o] && gsel[o] == PW'(p)) pop[p] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr    <= '0;
            out_v <= '0;
            out_q <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (load[o]) begin
                    out_q[o] <= head[gsel[o]];
                    out_v[o] <= 1'b1;
                    rr[o]    <= (gsel[o] == PW'(NP-1)) ? '0 : gsel[o] + PW'(1);
                end else if (bus.out_ready[o]) begin
                    out_v[o] <= 1'b0;
                end
            end
        end
    end

    // Several inputs may drop in one cycle; count all, saturate at max.
    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int p = 0; p < NP; p++)
            drop_sum = drop_sum + (DROP_W+1)'(drop[p]);
    end

    always_ff @(posedge clk) begin
        if (reset)                 drop_count <= '0;
        else if (drop_sum[DROP_W]) drop_count <= '1;
        else                       drop_count <= drop_sum[DROP_W-1:0];
    end

endmodule

// File: tb/tb_spine_xbar_router.sv
module tb_spine_xbar_router;
    localparam int NP = 11;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] drop_count;
    int          n_chk = 0;
    int          n_fail = 0;

    spine_xbar_router_if #(.NP(NP), .DWIDTH(DW)) bus ();

    spine_xbar_router dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [15:0] d);
        bus.in_valid[p]          = 1'b1;
        bus.in_data[p*DW +: DW]  = d;
    endtask

    function automatic logic [16:0] port_out(input int p);
        return {bus.out_valid[p], bus.out_data[p*DW +: DW]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic rdy;
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '1;
        repeat (3) tick();
        chk("rst_in_ready",  32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(|bus.out_data), 0);
        chk("rst_drop",      32'(drop_count), 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready",  32'(bus.in_ready), 32'h7FF);

        // Single flit to local leaf 0 from port 5, 2-cycle latency.
        drive(5, 16'h8123);
        tick();
        bus.in_valid = '0;
        chk("t1_not_yet",  32'(bus.out_valid), 0);
        tick();
        chk("t1_valid",    32'(bus.out_valid), 32'h001);
        chk("t1_data",     32'(bus.out_data[15:0]), 32'h8123);
        tick();
        chk("t1_clear",    32'(bus.out_valid), 0);

        // Remote mapping: dgid 3 -> 7, 0 -> 4, 6 -> 10, 9 -> drop.
        drive(0, 16'h3000);
        drive(1, 16'h9000);
        drive(2, 16'h6ABC);
        drive(3, 16'h0555);
        tick();
        bus.in_valid = '0;
        tick();
        chk("rm_valid", 32'(bus.out_valid), 32'h490);
        chk("rm_out7",  32'(bus.out_data[7*DW +: DW]),  32'h3000);
        chk("rm_out4",  32'(bus.out_data[4*DW +: DW]),  32'h0555);
        chk("rm_out10", 32'(bus.out_data[10*DW +: DW]), 32'h6ABC);
        chk("rm_drop",  32'(drop_count), 1);
        tick();
        chk("rm_clear", 32'(bus.out_valid), 0);

        // Round robin: ports 0,1,2 x 3 flits to leaf 3 (tag = port<<4 | seq).
        for (int p = 0; p < 3; p++) drive(p, 16'h8C00 | 16'(p << 4));
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i < 2) begin
                for (int p = 0; p < 3; p++) drive(p, 16'h8C00 | 16'(p << 4) | 16'(i + 1));
            end else begin
                bus.in_valid = '0;
            end
            tick();
            chk($sformatf("rr_%0d", i), 32'(port_out(3)),
                32'({1'b1, 16'h8C00 | 16'((i % 3) << 4) | 16'(i / 3)}));
        end
        tick();
        chk("rr_idle", 32'(bus.out_valid), 0);

        // Backpressure on output 1: 1 held + 8 buffered, then in_ready drops.
        bus.out_ready[1] = 1'b0;
        k = 0;
        for (int i = 0; i < 14; i++) begin
            drive(0, 16'h8400 | 16'(k));
            rdy = bus.in_ready[0];
            tick();
            if (rdy) k++;
        end
        bus.in_valid = '0;
        chk("bp_accepted", 32'(k), 9);
        chk("bp_in_ready", 32'(bus.in_ready[0]), 0);
        chk("bp_held",     32'(port_out(1)), 32'h18400);
        bus.out_ready[1] = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            chk($sformatf("bp_drain_%0d", i), 32'(port_out(1)), 32'({1'b1, 16'h8400 | 16'(i)}));
        end
        tick();
        chk("bp_done",     32'(bus.out_valid), 0);
        chk("bp_ready",    32'(bus.in_ready[0]), 1);

        // Drop counter ramp then saturation: all ports push unroutable flits.
        for (int p = 0; p < NP; p++) drive(p, 16'hF000);
        tick();
        tick();
        chk("sat_ramp", 32'(drop_count), 12);
        repeat (6100) tick();
        bus.in_valid = '0;
        tick();
        tick();
        chk("sat_max",   32'(drop_count), 32'hFFFF);
        chk("sat_novld", 32'(bus.out_valid), 0);

        // Reset mid-traffic: output 2 stalled with one flit held, 3 queued.
        bus.out_ready[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4, 16'h8800 | 16'(i));
            tick();
        end
        bus.in_valid = '0;
        tick();
        chk("mr_pre", 32'(port_out(2)), 32'h18800);
        reset = 1'b1;
        tick();
        chk("mr_out_valid", 32'(bus.out_valid), 0);
        chk("mr_drop",      32'(drop_count), 0);
        chk("mr_in_ready",  32'(bus.in_ready), 0);
        chk("mr_out_data",  32'(|bus.out_data), 0);
        bus.out_ready = '1;
        reset = 1'b0;
        #1;
        chk("mr_rel_ready", 32'(bus.in_ready), 32'h7FF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mr_stale_%0d", i), 32'(bus.out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
